uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver; next generation of the fixed 8-bit RX core. Owns its
//  oversampling baud timing, metastability sync, majority-vote sampling, runtime parity
//  and stop-bit modes, error flags and a valid/ready output holding register.
//  Sits between the RXD pad and the command/packet parser of the driver.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, legal 5..9, LSB received first
//  OVERSAMPLE  16  oversample ticks per bit, even, legal 8..32
//  DIV_W       16  width of baud_div
// PORTS
//  clk          in   1          system clock
//  reset        in   1          asynchronous, active-high reset
//  rxd          in   1          serial input, idle high, asynchronous to clk
//  rx_en        in   1          1 = start-bit detection allowed
//  baud_div     in   DIV_W      clk cycles per oversample tick minus 1 (0 = every clk)
//  parity_mode  in   2          00 none, 01 even, 10 odd, 11 treated as none
//  stop_bits    in   1          0 = one stop bit, 1 = two stop bits
//  rx_data      out  DATA_BITS  received word, stable while rx_valid
//  rx_valid     out  1          word + flags held, wait for rx_ready
//  rx_ready     in   1          consumer accepts word when rx_valid & rx_ready
//  parity_err   out  1          qualified by rx_valid: parity mismatch in held word
//  frame_err    out  1          qualified by rx_valid: a stop bit sampled low
//  overrun      out  1          1-cycle pulse: completed frame dropped (holding reg full)
//  busy         out  1          1 while state != IDLE
// BEHAVIOUR
//  - reset: state IDLE, sync flops = 1, counters 0, all outputs 0 (rx_data 0).
//  - rxd passes 2-flop sync; start = synced 1->0 edge while IDLE and rx_en.
//  - Tick gen: cnt 0..baud_div, tick when cnt==baud_div; cleared on start detect.
//  - Bit phase s counts ticks 0..OVERSAMPLE-1; M=OVERSAMPLE/2. Samples at s=M-1,M,M+1;
//    bit value = majority of 3, decided at s=M+1. Bit ends at s=OVERSAMPLE-1.
//  - baud_div, parity_mode, stop_bits latched at start detect; changes mid-frame ignored.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> DONE -> IDLE.
//    START: majority 1 -> false start, back to IDLE, no flags, no output.
//    DATA: DATA_BITS bits, shift in LSB first. PARITY only if mode 01/10;
//    even: XOR(data,parity)=0 required; odd: =1 required.
//    STOP: 1 or 2 bits; any stop majority 0 sets frame_err; leave STOP at decision
//    point (s=M+1) of last stop bit, so back-to-back frames resync on next edge.
//    DONE: one cycle, transfer to holding register -> rx_valid rises next clk.
//  - Holding reg: rx_valid set on DONE, cleared on rx_valid & rx_ready.
//    DONE with rx_valid=1 and rx_ready=0: new frame dropped, old word kept, overrun=1.
//    DONE with rx_valid=1 and rx_ready=1 same cycle: old accepted, new loaded, no overrun.
//  - rx_en low blocks new starts only; an in-flight frame completes normally.
//  - Break (rxd low whole frame): data 0, frame_err=1; no new start until rxd seen high.
//  - Async reset mid-frame: immediate return to reset state; partial frame discarded.
// TESTING
//  1 OVERSAMPLE=16, baud_div=3 (64 clk/bit), 8N1 0xA5 -> rx_data=0xA5, flags 0,
//    rx_valid rises within 64*10+8 clks of start edge, held until rx_ready.
//  2 8E1 0x07 with parity bit 1 -> parity_err=0; parity bit 0 -> parity_err=1;
//    8O1 0x07 parity 0 -> parity_err=0.
//  3 2-stop mode, 2nd stop driven low -> frame_err=1; rxd low glitch of 20 clk while
//    IDLE -> no rx_valid, busy returns 0.
//  4 Two back-to-back frames 0x11,0x22, rx_ready=0 -> first held 0x11, overrun pulse
//    once; repeat with rx_ready=1 at 2nd DONE -> 0x22 delivered, no overrun.
//  5 DATA_BITS=7, single-clk glitch at s=M on one data bit -> majority keeps value;
//    reset asserted mid-DATA -> outputs 0, next clean frame received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with majority-vote bit sampling, runtime
// parity/stop configuration, error flags and a valid/ready holding register.
module uart_rx_param #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    input  logic                 rx_en,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 stop_bits,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned PhaseW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW   = $clog2(DATA_BITS);

    localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(OVERSAMPLE - 1);
    localparam logic [PhaseW-1:0] PhasePre  = PhaseW'(OVERSAMPLE / 2 - 1);
    localparam logic [PhaseW-1:0] PhaseMid  = PhaseW'(OVERSAMPLE / 2);
    localparam logic [PhaseW-1:0] PhasePost = PhaseW'(OVERSAMPLE / 2 + 1);
    localparam logic [BitW-1:0]   BitLast   = BitW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic                 rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [PhaseW-1:0]    phase_q, phase_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           par_mode_q, par_mode_d;
    logic                 two_stop_q, two_stop_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 ovr_q, ovr_d;

    logic start_det, tick, decide, bit_end, maj, par_en;

    // Sync flops reset to idle-high so reset release never looks like a start edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            div_q      <= '0;
            phase_q    <= '0;
            bit_q      <= '0;
            stop_idx_q <= 1'b0;
            samp_q     <= '0;
            shift_q    <= '0;
            par_mode_q <= '0;
            two_stop_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            stop_idx_q <= stop_idx_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            par_mode_q <= par_mode_d;
            two_stop_q <= two_stop_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            ovr_q      <= ovr_d;
        end
    end

    assign start_det = (state_q == StIdle) && rx_en && rxd_prev_q && !rxd_sync_q;
    assign tick      = (state_q != StIdle) && (cnt_q == div_q);
    assign decide    = tick && (phase_q == PhasePost);
    assign bit_end   = tick && (phase_q == PhaseLast);
    assign maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_sync_q) |
                       (samp_q[1] & rxd_sync_q);
    // Modes 01/10 carry a parity bit; bit 1 of the mode selects odd
    assign par_en    = par_mode_q[0] ^ par_mode_q[1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        stop_idx_d = stop_idx_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        par_mode_d = par_mode_q;
        two_stop_d = two_stop_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        ovr_d      = 1'b0;

        if (state_q != StIdle) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                phase_d = (phase_q == PhaseLast) ? '0 : phase_q + 1'b1;
            end
        end else begin
            cnt_d   = '0;
            phase_d = '0;
        end

        if (tick && (phase_q == PhasePre)) begin
            samp_d[0] = rxd_sync_q;
        end
        if (tick && (phase_q == PhaseMid)) begin
            samp_d[1] = rxd_sync_q;
        end

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start_det) begin
                    state_d    = StStart;
                    div_d      = baud_div;
                    par_mode_d = parity_mode;
                    two_stop_d = stop_bits;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    bit_d      = '0;
                    stop_idx_d = 1'b0;
                end
            end
            StStart: begin
                if (decide && maj) begin
                    state_d = StIdle;
                end else if (bit_end) begin
                    state_d = StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (decide) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                end
                if (bit_end) begin
                    if (bit_q == BitLast) begin
                        state_d    = par_en ? StParity : StStop;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (decide) begin
                    perr_d = ^shift_q ^ maj ^ par_mode_q[1];
                end
                if (bit_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                // Leave at the last stop decision so a following start edge is not missed
                if (decide) begin
                    if (!maj) begin
                        ferr_d = 1'b1;
                    end
                    if (stop_idx_q == two_stop_q) begin
                        state_d = StDone;
                    end
                end else if (bit_end) begin
                    stop_idx_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (valid_q && !rx_ready) begin
                    ovr_d = 1'b1;
                end else begin
                    data_d     = shift_q;
                    perr_out_d = perr_q;
                    ferr_out_d = ferr_q;
                    valid_d    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_out_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: an 8-bit and a 7-bit instance, 64 clk per bit.
module tb_uart_rx_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        rxd8, rxd7, rx_en, stop_bits, rx_ready8, rx_ready7;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic [7:0]  rx_data8;
    logic [6:0]  rx_data7;
    logic        valid8, perr8, ferr8, ovr8, busy8;
    logic        valid7, perr7, ferr7, ovr7, busy7;

    always #5 clk = ~clk;

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .DIV_W(16)) u_dut8 (
        .clk(clk), .reset(reset), .rxd(rxd8), .rx_en(rx_en), .baud_div(baud_div),
        .parity_mode(parity_mode), .stop_bits(stop_bits), .rx_data(rx_data8),
        .rx_valid(valid8), .rx_ready(rx_ready8), .parity_err(perr8), .frame_err(ferr8),
        .overrun(ovr8), .busy(busy8)
    );

    uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(16), .DIV_W(16)) u_dut7 (
        .clk(clk), .reset(reset), .rxd(rxd7), .rx_en(rx_en), .baud_div(baud_div),
        .parity_mode(parity_mode), .stop_bits(stop_bits), .rx_data(rx_data7),
        .rx_valid(valid7), .rx_ready(rx_ready7), .parity_err(perr7), .frame_err(ferr7),
        .overrun(ovr7), .busy(busy7)
    );

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t q8[$];
    exp_t q7[$];
    exp_t e8, e7;
    int   total = 0;
    int   bad = 0;
    int   ovr_cnt8 = 0;
    int   ovr_cnt7 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare a held word against the scoreboard on every accepted handshake
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (valid8 && rx_ready8) begin
                    if (q8.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL word8_unexpected: actual=%0h required=none", rx_data8);
                    end else begin
                        e8 = q8.pop_front();
                        check("word8_data", 32'(rx_data8), 32'(e8.data));
                        check("word8_perr", 32'(perr8), 32'(e8.perr));
                        check("word8_ferr", 32'(ferr8), 32'(e8.ferr));
                    end
                end
                if (valid7 && rx_ready7) begin
                    if (q7.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL word7_unexpected: actual=%0h required=none", rx_data7);
                    end else begin
                        e7 = q7.pop_front();
                        check("word7_data", 32'(rx_data7), 32'(e7.data));
                        check("word7_perr", 32'(perr7), 32'(e7.perr));
                        check("word7_ferr", 32'(ferr7), 32'(e7.ferr));
                    end
                end
                if (ovr8) ovr_cnt8++;
                if (ovr7) ovr_cnt7++;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input bit to7, input logic v);
        if (to7) rxd7 = v;
        else rxd8 = v;
    endtask

    // One frame, 64 clk per bit; glitch_bit >= 0 inverts that bit for one clk at offset 36,
    // which lands on the s=M sample of the receiver.
    task automatic send_frame(input bit to7, input int nbits, input logic [8:0] data,
                              input bit par_en, input logic par_bit, input int nstop,
                              input logic stop2, input int glitch_bit);
        logic [15:0] fr;
        int          idx;
        logic        v;
        fr    = '1;
        fr[0] = 1'b0;
        for (int i = 0; i < nbits; i++) fr[1+i] = data[i];
        idx = 1 + nbits;
        if (par_en) begin
            fr[idx] = par_bit;
            idx++;
        end
        fr[idx] = 1'b1;
        if (nstop == 2) fr[idx+1] = stop2;
        @(posedge clk);
        #1;
        for (int b = 0; b < idx + nstop; b++) begin
            for (int c = 0; c < 64; c++) begin
                v = fr[b];
                if (b == glitch_bit && c == 36) v = ~v;
                drive(to7, v);
                @(posedge clk);
                #1;
            end
        end
        drive(to7, 1'b1);
    endtask

    task automatic wait_valid(input bit to7, input int budget, input string name);
        int n = 0;
        while (!(to7 ? valid7 : valid8) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(to7 ? valid7 : valid8), 32'd1);
    endtask

    task automatic accept(input bit to7);
        @(posedge clk);
        #1;
        if (to7) rx_ready7 = 1'b1;
        else rx_ready8 = 1'b1;
        @(posedge clk);
        #1;
        if (to7) rx_ready7 = 1'b0;
        else rx_ready8 = 1'b0;
    endtask

    task automatic push8(input logic [8:0] d, input logic p, input logic f);
        exp_t e;
        e.data = d;
        e.perr = p;
        e.ferr = f;
        q8.push_back(e);
    endtask

    task automatic push7(input logic [8:0] d, input logic p, input logic f);
        exp_t e;
        e.data = d;
        e.perr = p;
        e.ferr = f;
        q7.push_back(e);
    endtask

    task automatic txn8(input logic [8:0] d, input bit par_en, input logic par_bit,
                        input int nstop, input logic stop2, input logic ep, input logic ef,
                        input string name);
        push8(d, ep, ef);
        send_frame(1'b0, 8, d, par_en, par_bit, nstop, stop2, -1);
        wait_valid(1'b0, 16, name);
        accept(1'b0);
    endtask

    initial begin
        reset       = 1'b1;
        rxd8        = 1'b1;
        rxd7        = 1'b1;
        rx_en       = 1'b1;
        baud_div    = 16'd3;
        parity_mode = 2'b00;
        stop_bits   = 1'b0;
        rx_ready8   = 1'b0;
        rx_ready7   = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_data", 32'(rx_data8), 32'd0);
        check("rst_valid", 32'(valid8), 32'd0);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_perr", 32'(perr8), 32'd0);
        check("rst_ferr", 32'(ferr8), 32'd0);
        check("rst_ovr", 32'(ovr8), 32'd0);
        check("rst_valid7", 32'(valid7), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // 8N1 0xA5: latency bound, then held until accepted
        push8(9'h0A5, 1'b0, 1'b0);
        fork
            send_frame(1'b0, 8, 9'h0A5, 1'b0, 1'b0, 1, 1'b1, -1);
            wait_valid(1'b0, 648, "t1_latency");
        join
        repeat (20) @(negedge clk);
        check("t1_held_valid", 32'(valid8), 32'd1);
        check("t1_held_data", 32'(rx_data8), 32'hA5);
        accept(1'b0);
        @(negedge clk);
        check("t1_cleared", 32'(valid8), 32'd0);

        // Parity: 0x07 has three ones
        parity_mode = 2'b01;
        txn8(9'h007, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0, "t2_even_ok");
        txn8(9'h007, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, "t2_even_bad");
        parity_mode = 2'b10;
        txn8(9'h007, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, "t2_odd_ok");
        txn8(9'h007, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0, "t2_odd_bad");
        parity_mode = 2'b00;

        // Two stop bits, second low -> frame error; then a clean two-stop frame
        stop_bits = 1'b1;
        txn8(9'h03C, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, "t3_stop2_low");
        txn8(9'h0C3, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, "t3_stop2_ok");
        stop_bits = 1'b0;

        // 20-clk low glitch while idle: false start, no word
        @(posedge clk);
        #1 rxd8 = 1'b0;
        repeat (20) @(posedge clk);
        #1 rxd8 = 1'b1;
        @(negedge clk);
        check("t3_glitch_busy", 32'(busy8), 32'd1);
        repeat (80) @(negedge clk);
        check("t3_glitch_idle", 32'(busy8), 32'd0);
        check("t3_glitch_novalid", 32'(valid8), 32'd0);

        // Break: line low for 12 bit times
        push8(9'h000, 1'b0, 1'b1);
        @(posedge clk);
        #1 rxd8 = 1'b0;
        repeat (768) @(posedge clk);
        #1;
        wait_valid(1'b0, 4, "brk_valid");
        check("brk_no_restart", 32'(busy8), 32'd0);
        rxd8 = 1'b1;
        accept(1'b0);
        repeat (100) @(negedge clk);
        check("brk_idle_after_high", 32'(busy8), 32'd0);

        // rx_en low blocks new starts
        rx_en = 1'b0;
        send_frame(1'b0, 8, 9'h05A, 1'b0, 1'b0, 1, 1'b1, -1);
        repeat (10) @(negedge clk);
        check("en_blocked_valid", 32'(valid8), 32'd0);
        check("en_blocked_busy", 32'(busy8), 32'd0);
        rx_en = 1'b1;

        // Back-to-back with rx_ready low: first held, second dropped with one overrun
        push8(9'h011, 1'b0, 1'b0);
        send_frame(1'b0, 8, 9'h011, 1'b0, 1'b0, 1, 1'b1, -1);
        send_frame(1'b0, 8, 9'h022, 1'b0, 1'b0, 1, 1'b1, -1);
        repeat (10) @(negedge clk);
        check("t4_overrun_once", 32'(ovr_cnt8), 32'd1);
        check("t4_held_first", 32'(rx_data8), 32'h11);
        accept(1'b0);

        // Repeat with rx_ready raised exactly in the second DONE cycle
        push8(9'h011, 1'b0, 1'b0);
        push8(9'h022, 1'b0, 1'b0);
        send_frame(1'b0, 8, 9'h011, 1'b0, 1'b0, 1, 1'b1, -1);
        fork
            send_frame(1'b0, 8, 9'h022, 1'b0, 1'b0, 1, 1'b1, -1);
            begin
                repeat (620) @(posedge clk);
                #1 rx_ready8 = 1'b1;
                repeat (2) @(posedge clk);
                #1 rx_ready8 = 1'b0;
            end
        join
        repeat (10) @(negedge clk);
        check("t4b_no_overrun", 32'(ovr_cnt8), 32'd1);
        check("t4b_drained", 32'(valid8), 32'd0);

        // 7-bit instance: single-clk glitch at the mid sample of data bit 1
        push7(9'h055, 1'b0, 1'b0);
        send_frame(1'b1, 7, 9'h055, 1'b0, 1'b0, 1, 1'b1, 2);
        wait_valid(1'b1, 16, "t5_glitch_low_valid");
        accept(1'b1);
        send_frame(1'b1, 7, 9'h02A, 1'b0, 1'b0, 1, 1'b1, 2);
        wait_valid(1'b1, 16, "t5_glitch_high_valid");
        check("t5_glitch_high_data", 32'(rx_data7), 32'h2A);

        // Async reset in the middle of data bit 2, with a word still held
        @(posedge clk);
        #1 rxd7 = 1'b0;
        repeat (64 * 3 + 20) @(posedge clk);
        #3;
        check("t5_busy_before_reset", 32'(busy7), 32'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_busy", 32'(busy7), 32'd0);
        check("t5_rst_valid", 32'(valid7), 32'd0);
        check("t5_rst_data", 32'(rx_data7), 32'd0);
        check("t5_rst_data8", 32'(rx_data8), 32'd0);
        rxd7 = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        push7(9'h03B, 1'b0, 1'b0);
        send_frame(1'b1, 7, 9'h03B, 1'b0, 1'b0, 1, 1'b1, -1);
        wait_valid(1'b1, 16, "t5_after_reset_valid");
        accept(1'b1);

        repeat (5) @(negedge clk);
        check("q8_empty", 32'(q8.size()), 32'd0);
        check("q7_empty", 32'(q7.size()), 32'd0);
        check("ovr7_none", 32'(ovr_cnt7), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
